// File: rtl/cdi_reset_pkg.sv
// Shared types and defaults for the CDI reset sequencer.
// Holds the FSM state enum, default parameters and the counter-width helper.
package cdi_reset_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT_LOCK,
        MEM_UP,
        RUN
    } rstseq_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_CYCLES = 60000;
    localparam int DEF_CPU_DELAY   = 1024;
    localparam int DEF_CE_DIV      = 4;

    // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/cdi_sync_bit.sv
// Generic single-bit multi-flop synchronizer for an asynchronous input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module cdi_sync_bit
    import cdi_reset_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdi_reset_sequencer.sv
// Staged reset sequencer: mem_rst, then cpu_rst, plus a phase-locked cpu_ce.
// Ports: clk, rst (sync, active-high), pll_locked (async), soft_reset_req
// (only with CDI_RSTSEQ_SOFT_RESET_EN), mem_rst, cpu_rst, cpu_ce, ready.
// Optional feature macro: CDI_RSTSEQ_SOFT_RESET_EN (CPU-only soft reset).
module cdi_reset_sequencer
    import cdi_reset_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int CPU_DELAY   = DEF_CPU_DELAY,
    parameter int CE_DIV      = DEF_CE_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
`ifdef CDI_RSTSEQ_SOFT_RESET_EN
    input  logic soft_reset_req,
`endif
    output logic mem_rst,
    output logic cpu_rst,
    output logic cpu_ce,
    output logic ready
);

    localparam int CNT_W = cnt_width(LOCK_CYCLES, CPU_DELAY);
    localparam int CE_W  = $clog2(CE_DIV);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);
    localparam logic [CE_W-1:0]  CE_LAST   = CE_W'(CE_DIV - 1);

    rstseq_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CE_W-1:0]  ce_cnt_q, ce_cnt_d;
    logic             mem_rst_q, mem_rst_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             ready_q, ready_d;
    logic             ce_hold;
    logic             locked_s;

    cdi_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

`ifdef CDI_RSTSEQ_SOFT_RESET_EN
    logic soft_s;

    cdi_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_soft (
        .clk (clk),
        .rst (rst),
        .d   (soft_reset_req),
        .q   (soft_s)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!locked_s) begin
            // Lock loss outranks every other transition.
            state_d = HOLD;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
                WAIT_LOCK: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d = MEM_UP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MEM_UP: begin
                    if (cnt_q == CPU_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
`ifdef CDI_RSTSEQ_SOFT_RESET_EN
            // Soft reset parks the CPU in MEM_UP; memory side stays up.
            if (soft_s && (state_q == MEM_UP || state_q == RUN)) begin
                state_d = MEM_UP;
                cnt_d   = '0;
            end
`endif
        end
    end

    always_comb begin
        mem_rst_d = (state_d == HOLD) || (state_d == WAIT_LOCK);
        cpu_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);

        // Counting starts on the edge after mem_rst falls, so the first
        // pulse lands exactly CE_DIV cycles after the fall.
        ce_hold   = mem_rst_q || mem_rst_d;
        ce_cnt_d  = '0;
        cpu_ce_d  = 1'b0;
        if (!ce_hold) begin
            cpu_ce_d = (ce_cnt_q == CE_LAST);
            if (ce_cnt_q != CE_LAST) begin
                ce_cnt_d = ce_cnt_q + CE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            ce_cnt_q  <= '0;
            mem_rst_q <= 1'b1;
            cpu_rst_q <= 1'b1;
            cpu_ce_q  <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ce_cnt_q  <= ce_cnt_d;
            mem_rst_q <= mem_rst_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_ce_q  <= cpu_ce_d;
            ready_q   <= ready_d;
        end
    end

    assign mem_rst = mem_rst_q;
    assign cpu_rst = cpu_rst_q;
    assign cpu_ce  = cpu_ce_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_cdi_reset_sequencer.sv
// Directed self-checking bench for cdi_reset_sequencer.
// Edge numbers count posedges after rst is released; checks sample #1 later.
module tb_cdi_reset_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic pll_locked;
    logic soft_reset_req;
    logic mem_rst;
    logic cpu_rst;
    logic cpu_ce;
    logic ready;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    cdi_reset_sequencer #(
        .SYNC_STAGES (2),
        .LOCK_CYCLES (100),
        .CPU_DELAY   (20),
        .CE_DIV      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
`ifdef CDI_RSTSEQ_SOFT_RESET_EN
        .soft_reset_req (soft_reset_req),
`endif
        .mem_rst        (mem_rst),
        .cpu_rst        (cpu_rst),
        .cpu_ce         (cpu_ce),
        .ready          (ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s @E%0d: observed %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic m, input logic c,
                           input logic e, input logic r);
        chk({tag, ".mem_rst"}, mem_rst, m);
        chk({tag, ".cpu_rst"}, cpu_rst, c);
        chk({tag, ".cpu_ce"},  cpu_ce,  e);
        chk({tag, ".ready"},   ready,   r);
    endtask

    initial begin
        rst            = 1'b1;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        step();
        step();
        step();
        chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0);

        // Power-up: lock first sampled at E5 -> WAIT_LOCK at E7 -> MEM_UP at E107.
        rst = 1'b0;
        cyc = 0;
        run_to(4);
        pll_locked = 1'b1;
        run_to(106);
        chk_all("pre_mem", 1'b1, 1'b1, 1'b0, 1'b0);
        run_to(107);
        chk_all("mem_fall", 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(110);
        chk("ce_e110", cpu_ce, 1'b0);
        run_to(111);
        chk("ce_e111", cpu_ce, 1'b1);
        run_to(112);
        chk("ce_e112", cpu_ce, 1'b0);
        run_to(115);
        chk("ce_e115", cpu_ce, 1'b1);
        run_to(119);
        chk("ce_e119", cpu_ce, 1'b1);
        run_to(126);
        chk_all("pre_run", 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(127);
        chk_all("run", 1'b0, 1'b0, 1'b1, 1'b1);

        // Lock loss in RUN: first sampled low at E128 -> HOLD at E130.
        pll_locked = 1'b0;
        run_to(129);
        chk("loss_e129.mem_rst", mem_rst, 1'b0);
        run_to(130);
        chk_all("loss_e130", 1'b1, 1'b1, 1'b0, 1'b0);
        run_to(131);
        chk("loss_e131.cpu_ce", cpu_ce, 1'b0);

        // Relock at E136 -> WAIT_LOCK at E138; cnt==50 after E188.
        run_to(135);
        pll_locked = 1'b1;
        run_to(188);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        // Glitch: HOLD at E191, WAIT_LOCK at E192, MEM_UP at E292.
        run_to(238);
        chk("glitch_e238.mem_rst", mem_rst, 1'b1);
        run_to(291);
        chk("glitch_e291.mem_rst", mem_rst, 1'b1);
        run_to(292);
        chk_all("relock_fall", 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(295);
        chk("relock_ce_e295", cpu_ce, 1'b0);
        run_to(296);
        chk("relock_ce_e296", cpu_ce, 1'b1);
        run_to(300);
        chk("relock_ce_e300", cpu_ce, 1'b1);

        // One-cycle rst in MEM_UP, sampled at E301.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        // Sync restarts: WAIT_LOCK at E304 -> MEM_UP at E404 -> RUN at E424.
        run_to(403);
        chk("rerun_e403.mem_rst", mem_rst, 1'b1);
        run_to(404);
        chk("rerun_e404.mem_rst", mem_rst, 1'b0);
        run_to(407);
        chk("rerun_ce_e407", cpu_ce, 1'b0);
        run_to(408);
        chk("rerun_ce_e408", cpu_ce, 1'b1);
        run_to(423);
        chk("rerun_e423.cpu_rst", cpu_rst, 1'b1);
        run_to(424);
        chk_all("rerun_run", 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef CDI_RSTSEQ_SOFT_RESET_EN
        // Soft reset sampled high E431..E440; sync high E432..E441.
        run_to(430);
        soft_reset_req = 1'b1;
        run_to(433);
        chk_all("soft_in", 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(436);
        chk("soft_ce_e436", cpu_ce, 1'b1);
        run_to(440);
        soft_reset_req = 1'b0;
        chk("soft_ce_e440", cpu_ce, 1'b1);
        run_to(444);
        chk("soft_ce_e444", cpu_ce, 1'b1);
        chk("soft_e444.mem_rst", mem_rst, 1'b0);
        run_to(461);
        chk("soft_e461.cpu_rst", cpu_rst, 1'b1);
        run_to(462);
        chk_all("soft_out", 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
